// File: rtl/stumps_bist_pkg.sv
// Shared state encoding and counter sizing for the STUMPS BIST sequencer.
package stumps_bist_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SEED    = 3'd1,
      SHIFT   = 3'd2,
      CAPTURE = 3'd3,
      UNLOAD  = 3'd4,
      COMPARE = 3'd5,
      DONE    = 3'd6
   } bist_state_e;

   // Bits needed to hold values 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bist_cycle_counter.sv
// Up-counter with synchronous clear (priority over enable) and a combinational terminal-count flag.
module bist_cycle_counter #(
   parameter int Width    = 4,
   parameter int Terminal = 3
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [Width-1:0] o_count,
   output logic             o_terminal
);

   logic [Width-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count    = r_count;
   assign o_terminal = (r_count == Width'(Terminal));

endmodule

// File: rtl/stumps_bist_sequencer.sv
// STUMPS BIST run sequencer: seeds, shifts/captures NumPatterns patterns with overlapped unload,
// then compares the final MISR signature against the golden value.
module stumps_bist_sequencer
   import stumps_bist_pkg::*;
#(
   parameter int ShiftSize   = 45,
   parameter int NumPatterns = 45,
   parameter int SigWidth    = 16
) (
   input  logic                                  clk,
   input  logic                                  rstBarIn,
   input  logic                                  start,
   input  logic                                  abort,
   input  logic [SigWidth-1:0]                   misrSig,
   input  logic [SigWidth-1:0]                   goldenSig,
   output logic                                  NbarT,
   output logic                                  rstOut,
   output logic                                  seedLoad,
   output logic                                  PRPG_En,
   output logic                                  SRSG_En,
   output logic                                  SISA_En,
   output logic                                  MISR_En,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  pass,
   output logic [cnt_width(NumPatterns+1)-1:0]   patCount,
   output logic [2:0]                            o_dbg_state,
   output logic [cnt_width(ShiftSize)-1:0]       o_dbg_sht_count
);

   localparam int ShtW = cnt_width(ShiftSize);
   localparam int PatW = cnt_width(NumPatterns + 1);

   bist_state_e     r_state;
   logic            r_done;
   logic            r_pass;
   logic [ShtW-1:0] w_sht_count;
   logic [PatW-1:0] w_pat_count;
   logic            w_sht_term;
   logic            w_pat_term;
   logic            w_shifting;
   logic            w_sht_en;
   logic            w_sht_clr;
   logic            w_pat_en;
   logic            w_pat_clr;

   // The shift counter holds at its terminal value so it never wraps; leaving SHIFT/UNLOAD clears it.
   assign w_shifting = (r_state == SHIFT) || (r_state == UNLOAD);
   assign w_sht_en   = w_shifting && !w_sht_term;
   assign w_sht_clr  = abort || !w_shifting;
   assign w_pat_en   = (r_state == CAPTURE);
   assign w_pat_clr  = abort || (r_state == SEED) ||
                       (start && ((r_state == IDLE) || (r_state == DONE)));

   bist_cycle_counter #(.Width(ShtW), .Terminal(ShiftSize - 1)) u_sht_counter (
      .i_clk      (clk),
      .i_rst_n    (rstBarIn),
      .i_clr      (w_sht_clr),
      .i_en       (w_sht_en),
      .o_count    (w_sht_count),
      .o_terminal (w_sht_term)
   );

   bist_cycle_counter #(.Width(PatW), .Terminal(NumPatterns - 1)) u_pat_counter (
      .i_clk      (clk),
      .i_rst_n    (rstBarIn),
      .i_clr      (w_pat_clr),
      .i_en       (w_pat_en),
      .o_count    (w_pat_count),
      .o_terminal (w_pat_term)
   );

   always_ff @(posedge clk or negedge rstBarIn) begin
      if (!rstBarIn) begin
         r_state <= IDLE;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
      end else if (abort) begin
         r_state <= IDLE;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= SEED;
                  r_pass  <= 1'b0;
               end
            end
            SEED:    r_state <= SHIFT;
            SHIFT:   if (w_sht_term) r_state <= CAPTURE;
            CAPTURE: r_state <= w_pat_term ? UNLOAD : SHIFT;
            UNLOAD:  if (w_sht_term) r_state <= COMPARE;
            COMPARE: begin
               r_state <= DONE;
               r_done  <= 1'b1;
               r_pass  <= (misrSig == goldenSig);
            end
            DONE: begin
               if (start) begin
                  r_state <= SEED;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_pass  <= 1'b0;
            end
         endcase
      end
   end

   // COMPARE stays in test mode: only CAPTURE drops NbarT while busy.
   always_comb begin
      NbarT    = 1'b0;
      rstOut   = 1'b0;
      seedLoad = 1'b0;
      PRPG_En  = 1'b0;
      SRSG_En  = 1'b0;
      SISA_En  = 1'b0;
      MISR_En  = 1'b0;
      busy     = 1'b0;
      case (r_state)
         SEED: begin
            rstOut   = 1'b1;
            seedLoad = 1'b1;
            NbarT    = 1'b1;
            busy     = 1'b1;
         end
         SHIFT: begin
            PRPG_En = 1'b1;
            SRSG_En = 1'b1;
            SISA_En = 1'b1;
            MISR_En = (w_pat_count != '0);
            NbarT   = 1'b1;
            busy    = 1'b1;
         end
         CAPTURE: busy = 1'b1;
         UNLOAD: begin
            SRSG_En = 1'b1;
            MISR_En = 1'b1;
            NbarT   = 1'b1;
            busy    = 1'b1;
         end
         COMPARE: begin
            NbarT = 1'b1;
            busy  = 1'b1;
         end
         default: ;
      endcase
   end

   assign done            = r_done;
   assign pass            = r_pass;
   assign patCount        = w_pat_count;
   assign o_dbg_state     = r_state;
   assign o_dbg_sht_count = w_sht_count;

endmodule

// File: tb/tb_stumps_bist_sequencer.sv
// Bench for stumps_bist_sequencer: nominal/fail runs, restart, abort, async reset and a minimal-size instance.
module tb_stumps_bist_sequencer;
   import stumps_bist_pkg::*;

   localparam int SA = 4;
   localparam int NA = 3;
   localparam int SB = 2;
   localparam int NB = 1;
   localparam int SW = 16;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
   logic [SW-1:0] misr_a = 16'hA5C3, gold_a = 16'hA5C3;
   logic [SW-1:0] misr_b = 16'h1234, gold_b = 16'h1234;

   logic nbart_a, rstout_a, seedload_a, prpg_a, srsg_a, sisa_a, misren_a, busy_a, done_a, pass_a;
   logic nbart_b, rstout_b, seedload_b, prpg_b, srsg_b, sisa_b, misren_b, busy_b, done_b, pass_b;
   logic [1:0] pat_a, sht_a;
   logic [0:0] pat_b, sht_b;
   logic [2:0] st_a, st_b;

   logic       sel = 1'b0;
   logic [9:0] outs_a, outs_b, m_outs;
   logic [1:0] m_pat;
   logic [2:0] m_st;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   stumps_bist_sequencer #(.ShiftSize(SA), .NumPatterns(NA), .SigWidth(SW)) dut_a (
      .clk(clk), .rstBarIn(rst_n), .start(start_a), .abort(abort_a),
      .misrSig(misr_a), .goldenSig(gold_a),
      .NbarT(nbart_a), .rstOut(rstout_a), .seedLoad(seedload_a), .PRPG_En(prpg_a),
      .SRSG_En(srsg_a), .SISA_En(sisa_a), .MISR_En(misren_a), .busy(busy_a),
      .done(done_a), .pass(pass_a), .patCount(pat_a),
      .o_dbg_state(st_a), .o_dbg_sht_count(sht_a)
   );

   stumps_bist_sequencer #(.ShiftSize(SB), .NumPatterns(NB), .SigWidth(SW)) dut_b (
      .clk(clk), .rstBarIn(rst_n), .start(start_b), .abort(abort_b),
      .misrSig(misr_b), .goldenSig(gold_b),
      .NbarT(nbart_b), .rstOut(rstout_b), .seedLoad(seedload_b), .PRPG_En(prpg_b),
      .SRSG_En(srsg_b), .SISA_En(sisa_b), .MISR_En(misren_b), .busy(busy_b),
      .done(done_b), .pass(pass_b), .patCount(pat_b),
      .o_dbg_state(st_b), .o_dbg_sht_count(sht_b)
   );

   // Output vector bits: 9 NbarT, 8 rstOut, 7 seedLoad, 6 PRPG, 5 SRSG, 4 SISA, 3 MISR, 2 busy, 1 done, 0 pass
   assign outs_a = {nbart_a, rstout_a, seedload_a, prpg_a, srsg_a, sisa_a, misren_a, busy_a, done_a, pass_a};
   assign outs_b = {nbart_b, rstout_b, seedload_b, prpg_b, srsg_b, sisa_b, misren_b, busy_b, done_b, pass_b};
   assign m_outs = sel ? outs_b : outs_a;
   assign m_pat  = sel ? {1'b0, pat_b} : pat_a;
   assign m_st   = sel ? st_b : st_a;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One full run on the selected instance; the expected result is queued when start is driven.
   task automatic run(input logic s, input logic [SW-1:0] golden);
      int S, N, lat, n_prpg, n_misr, n_misr_sh, n_nbt_low, n_cap;
      logic [SW-1:0] misr;
      logic [15:0] g;
      S = s ? SB : SA;
      N = s ? NB : NA;
      misr = s ? misr_b : misr_a;
      lat = 0; n_prpg = 0; n_misr = 0; n_misr_sh = 0; n_nbt_low = 0; n_cap = 0;
      sel = s;
      @(negedge clk);
      if (s) begin gold_b = golden; start_b = 1'b1; end
      else   begin gold_a = golden; start_a = 1'b1; end
      exp_q.push_back({4'd0, 3'(N), (misr == golden), 8'(3 + N * (S + 1) + S)});
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start_a = 1'b0;
            start_b = 1'b0;
            check_val("seed_outputs", 32'(m_outs), 32'b11_1000_0100);
            check_val("seed_patcount", 32'(m_pat), 0);
         end
         if (m_outs[1]) begin
            lat = k;
            break;
         end
         if (m_outs[6]) n_prpg++;
         if (m_outs[3]) n_misr++;
         if (m_outs[3] && m_outs[6]) n_misr_sh++;
         if (m_outs[2] && !m_outs[9]) n_nbt_low++;
         if (m_st == CAPTURE) n_cap++;
      end
      g = exp_q.pop_front();
      check_val("done_latency", 32'(lat), 32'(g[7:0]));
      check_val("pass", 32'(m_outs[0]), 32'(g[8]));
      check_val("patcount_done", 32'(m_pat), 32'(g[11:9]));
      check_val("busy_in_done", 32'(m_outs[2]), 0);
      check_val("prpg_cycles", 32'(n_prpg), 32'(N * S));
      check_val("misr_cycles", 32'(n_misr), 32'(N * S));
      check_val("misr_in_shift", 32'(n_misr_sh), 32'((N - 1) * S));
      check_val("nbart_low_busy", 32'(n_nbt_low), 32'(N));
      check_val("captures", 32'(n_cap), 32'(N));
      @(negedge clk);
      check_val("done_hold", 32'({m_outs[1], m_outs[0]}), 32'({1'b1, g[8]}));
   endtask

   initial begin
      #12;
      check_val("reset_outs_a", 32'(outs_a), 0);
      check_val("reset_outs_b", 32'(outs_b), 0);
      check_val("reset_pat_a", 32'(pat_a), 0);
      check_val("reset_state_a", 32'(st_a), 32'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_val("idle_outs_a", 32'(outs_a), 0);

      // start and abort together in IDLE stays IDLE
      start_a = 1'b1; abort_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0; abort_a = 1'b0;
      check_val("start_abort_idle", 32'(st_a), 32'(IDLE));

      run(1'b0, 16'hA5C3);
      run(1'b0, 16'hA5C3);
      run(1'b0, 16'hA5C2);

      // Abort in the 2nd SHIFT cycle of pattern 2 (cycle 8 after start)
      sel = 1'b0;
      @(negedge clk);
      start_a = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) start_a = 1'b0;
      end
      check_val("pre_abort_state", 32'(st_a), 32'(SHIFT));
      check_val("pre_abort_sht", 32'(sht_a), 1);
      check_val("pre_abort_pat", 32'(pat_a), 1);
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      check_val("abort_state", 32'(st_a), 32'(IDLE));
      check_val("abort_outs", 32'(outs_a), 0);
      check_val("abort_pat", 32'(pat_a), 0);
      repeat (2) @(negedge clk);
      run(1'b0, 16'hA5C3);

      // Async reset in the middle of UNLOAD (cycle 18 after start)
      @(negedge clk);
      start_a = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (k == 1) start_a = 1'b0;
      end
      check_val("pre_reset_state", 32'(st_a), 32'(UNLOAD));
      #2 rst_n = 1'b0;
      #1;
      check_val("async_reset_outs", 32'(outs_a), 0);
      check_val("async_reset_pat", 32'(pat_a), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_val("post_reset_state", 32'(st_a), 32'(IDLE));
      check_val("post_reset_outs", 32'(outs_a), 0);
      run(1'b0, 16'hA5C3);

      // Minimal instance: ShiftSize=2, NumPatterns=1
      run(1'b1, 16'h1234);

      if (exp_q.size() != 0) check_val("queue_empty", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/stumps_bist_sequencer.md
Name: stumps_bist_sequencer

Overview:
Full-run BIST sequencer for the STUMPS test architecture. Drives PRPG, scan-chain shift/capture and MISR through a configurable number of test patterns. Overlaps response unload with the next pattern load, then compares the final MISR signature with a golden value. It sits above the PRPG/SRSG/SISA/MISR datapath and is started and aborted by a test-access host with a start/done handshake.

Parameters:
ShiftSize, 45, scan-chain length in shift cycles (legal range ≥2)
NumPatterns, 45, number of test patterns applied (legal range ≥1)
SigWidth, 16, MISR signature width

Ports:
clk  input  1  system clock
rstBarIn  input  1  reset, asynchronous, active-low
start  input  1  begin run; sampled only in IDLE or DONE
abort  input  1  synchronous abort of run
misrSig  input  SigWidth  current MISR contents
goldenSig  input  SigWidth  expected signature, sampled in COMPARE
NbarT  output  1  1 = test/shift mode, 0 = normal/capture
rstOut  output  1  CUT/datapath reset
seedLoad  output  1  load PRPG/MISR seed
PRPG_En  output  1  advance PRPG
SRSG_En  output  1  shift scan chains
SISA_En  output  1  SISA compaction enable
MISR_En  output  1  MISR compaction enable
busy  output  1  run in progress
done  output  1  run finished, result valid
pass  output  1  signature matched; valid while done=1
patCount  output  $clog2(NumPatterns+1)  patterns captured so far

Behaviour:
- Reset (rstBarIn=0, async): state=IDLE, counters=0, pass=0. All outputs 0, including NbarT.
- Outputs are a decode of the registered state plus counters. done and pass are registered.
- IDLE: all outputs 0. start=1 → SEED next cycle.
- SEED (1 cycle):
  - outputs: rstOut=1, seedLoad=1, NbarT=1, busy=1
  - actions: shtCount cleared, patCount cleared, pass cleared
  - next: SHIFT
- SHIFT (exactly ShiftSize cycles, shtCount 0..ShiftSize-1):
  - outputs: PRPG_En=1, SRSG_En=1, SISA_En=1, NbarT=1, busy=1
  - MISR_En=1 only when patCount>0; the chain then holds the previous capture
  - next: CAPTURE when shtCount=ShiftSize-1
- CAPTURE (1 cycle):
  - outputs: NbarT=0, busy=1, all enables 0
  - actions: patCount increments, shtCount cleared
  - next: UNLOAD if the pre-increment patCount = NumPatterns-1, else SHIFT
- UNLOAD (ShiftSize cycles):
  - outputs: SRSG_En=1, MISR_En=1, NbarT=1, busy=1
  - PRPG_En=0 and SISA_En=0
  - next: COMPARE
- COMPARE (1 cycle): busy=1; pass <= (misrSig == goldenSig) on the exit edge; next DONE.
- DONE:
  - outputs: done=1, busy=0; pass holds; patCount holds (=NumPatterns)
  - next: start=1 → SEED (done drops next cycle); otherwise stay in DONE
- Abort: abort=1 in any state other than IDLE → IDLE next cycle; done=0, pass=0, counters cleared.
  - abort has priority over start and over every transition.
- start is ignored outside IDLE and DONE. start and abort together in IDLE → remain IDLE.
- Run length: start sampled at edge t0 → done=1 from cycle t0+3+NumPatterns·(ShiftSize+1)+ShiftSize.
- Counters never wrap:
  - shtCount width $clog2(ShiftSize)
  - terminal compare on ShiftSize-1, clear on SEED/CAPTURE/abort
- Async reset mid-run immediately forces the reset values. No partial result is retained.
- Illegal state encoding → IDLE next cycle.

Decomposition:
- Package stumps_bist_pkg holds:
  - the state encoding constants IDLE, SEED, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE (3 bits)
  - a function for the counter width
- Sub-module bist_cycle_counter (parameter Terminal): up-counter with clr, en and registered-free terminal flag.
  - instantiated twice: shift counter, pattern counter

Test Plan:
- Nominal run, ShiftSize=4, NumPatterns=3, goldenSig=misrSig=16'hA5C3, start pulse at t0:
  - done=1 at t0+22
  - pass=1
  - PRPG_En high 12 cycles, MISR_En high 12 cycles, NbarT low 3 cycles during busy
  - patCount=3
- Same run with goldenSig=16'hA5C2 → done=1 at t0+22, pass=0.
- abort asserted in the 2nd SHIFT cycle of pattern 2:
  - next cycle IDLE, all outputs 0, patCount=0
  - a fresh start then completes at the full 22-cycle latency
- rstBarIn pulled low mid-UNLOAD (asynchronously, between edges):
  - outputs 0 immediately; busy=0, done=0
  - on release, stays IDLE until start
- Restart from DONE, start held 1 cycle: SEED next cycle, done=0, pass cleared, second run identical to the first.
- Boundary NumPatterns=1, ShiftSize=2:
  - MISR_En never high in SHIFT
  - exactly one CAPTURE
  - done at t0+8
